mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port of the RISC core between instruction fetch (IF) and data memory access (DM).
- Drives the select of the 32-bit address/data 2:1 mux in front of memory: sel=0 routes the IF side, sel=1 routes the DM side.
- Sequences each access through grant, wait-for-acknowledge and response, with round-robin fairness and a timeout abort.

Parameters:
- DATA_W, 32, data bus width
- ADDR_W, 32, address bus width
- TIMEOUT, 15, max cycles in BUSY waiting for mem_ack before abort (1..255)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  registered fetch data, valid with if_done
- dm_req  in  1  data request; held high until dm_done
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_done  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_W  registered read data, valid with dm_done
- err  out  1  one-cycle pulse with the done pulse of a timed-out access
- sel  out  1  mux select: 0=IF, 1=DM
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address, muxed by sel
- mem_wdata  out  DATA_W  memory write data, dm_wdata when sel=1, else 0
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, single cycle

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; sel=0, last_dm=0, cnt=0. if_done, dm_done, err, mem_en, mem_we are 0. if_rdata and dm_rdata are 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE, mem_en=0.
  - One request: grant that side.
  - Both requests: grant DM unless last_dm=1, in which case grant IF (round-robin).
  - On grant: register sel and owner, set last_dm=(owner==DM), clear cnt, go to BUSY.
- BUSY:
  - mem_en=1.
  - mem_we = dm_we when sel=1, otherwise 0.
  - mem_addr and mem_wdata are combinational from sel and the owner's inputs.
  - mem_ack=1: capture mem_rdata into the owner's rdata register (DM writes also capture, value is don't-care). Go to RESP.
  - mem_ack=0: cnt increments. When cnt reaches TIMEOUT-1 with no ack, set the abort flag, leave the rdata register unchanged, and go to RESP.
- RESP:
  - mem_en=0.
  - The owner's done=1 for exactly this cycle.
  - err=1 if the abort flag is set. The flag clears on exit.
  - Next state is IDLE.
- Latency: request sampled in IDLE at edge 0. BUSY runs from edge 1. With ack in the first BUSY cycle, done is high in the cycle after edge 2. Minimum total is 3 cycles from request to IDLE.
- The owner's req is not re-sampled in BUSY or RESP. Dropping req mid-access does not cancel the access.
- The requester must drop req in the cycle after done. A req still high in IDLE starts a new access.
- The non-owner's req is ignored until IDLE. That request is then served first if the owner's req is gone, or via round-robin if both requests are present.
- sel is held stable from the grant through RESP and keeps its value in IDLE, so there are no glitches on the mux.
- mem_ack outside BUSY is ignored.
- Reset asserted mid-access aborts immediately to the reset values above. No done pulse is produced.
- Starvation bound: under continuous contention, each side waits at most one foreign access.

Test Plan:
- Reset: hold rst_n=0 mid-BUSY. Required: all outputs 0 immediately without a clock edge; after release, state=IDLE and sel=0.
- Single fetch: if_req=1, if_addr=0x0000_0040; memory acks in the 2nd BUSY cycle with mem_rdata=0xDEAD_BEEF. Required: sel=0, mem_en high for 2 cycles, mem_addr=0x40, mem_we=0; if_done pulses 1 cycle with if_rdata=0xDEAD_BEEF; dm_done=0.
- Data write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x1234_5678. Required: sel=1, mem_we=1, mem_wdata=0x1234_5678; dm_done pulses 1 cycle; err=0.
- Contention: if_req and dm_req held high together from reset, each requester re-requests right after its done. Required: grants alternate DM, IF, DM, IF; sel=1,0,1,0; no side is granted twice in a row.
- Timeout: TIMEOUT=4, dm_req read, mem_ack never asserts. Required: BUSY lasts 4 cycles, then dm_done=1 and err=1 in the same cycle; dm_rdata keeps its previous value; IF is served next.
- Stray ack plus request drop: mem_ack=1 pulsed in IDLE produces no done. if_req dropped mid-BUSY still completes, and if_done pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and data memory (DM).
// Each access runs IDLE -> BUSY -> RESP. Grants alternate under contention, and a timeout aborts a stalled access.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, nxt_state;
    logic       nxt_sel;
    logic       last_dm, nxt_last_dm;
    logic [7:0] cnt, nxt_cnt;
    logic       abort, nxt_abort;
    logic       grant_dm;

    // Handshake: a requester holds req high until it sees its one-cycle done pulse,
    // then drops req the next cycle; req is only sampled in IDLE, and sel identifies the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            last_dm <= 1'b0;
            cnt     <= '0;
            abort   <= 1'b0;
        end else begin
            state   <= nxt_state;
            sel     <= nxt_sel;
            last_dm <= nxt_last_dm;
            cnt     <= nxt_cnt;
            abort   <= nxt_abort;
        end
    end

    // DM wins a tie unless it also won the previous grant.
    assign grant_dm = dm_req && (!if_req || !last_dm);

    always_comb begin
        nxt_state   = state;
        nxt_sel     = sel;
        nxt_last_dm = last_dm;
        nxt_cnt     = cnt;
        nxt_abort   = abort;
        unique case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    nxt_sel     = grant_dm;
                    nxt_last_dm = grant_dm;
                    nxt_cnt     = '0;
                    nxt_state   = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    nxt_state = RESP;
                end else if (cnt == CNT_LAST) begin
                    nxt_abort = 1'b1;
                    nxt_state = RESP;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            RESP: begin
                nxt_abort = 1'b0;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Read data lands only in the owner's register; an aborted access leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (state == BUSY && mem_ack) begin
            if (sel) dm_rdata <= mem_rdata;
            else     if_rdata <= mem_rdata;
        end
    end

    assign mem_en    = (state == BUSY);
    assign mem_we    = (state == BUSY) && sel && dm_we;
    assign mem_addr  = sel ? dm_addr : if_addr;
    assign mem_wdata = sel ? dm_wdata : '0;
    assign if_done   = (state == RESP) && !sel;
    assign dm_done   = (state == RESP) && sel;
    assign err       = (state == RESP) && abort;
    assign fsm_state = state;

endmodule
